axi_mem_responder: RTL and testbench

AXI4 subordinate that terminates the 64-bit AXI master port of the opentitan top (the `axi_req`/`axi_rsp` struct pair) with a flop-based memory. It replaces the randomised behavioural slave where deterministic, synthesisable read-back is needed: in FPGA builds, in gate-level simulation, and as a preload/checker target for JTAG system-bus-access tests. It handles one transaction at a time and supports FIXED and INCR bursts, with WRAP bursts treated as INCR.

---
 rtl/axi_mem_responder_pkg.sv | 88 ++++++++
 rtl/axi_mem_bank.sv | 33 +++
 rtl/axi_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_responder_pkg.sv
// Shared types and helpers for the flop-based AXI4 memory responder.
// Default channel structs match the 64-bit data / 64-bit address / 8-bit ID master port.
package axi_mem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWdata = 2'd1,
    StWresp = 2'd2,
    StRdata = 2'd3
  } axi_mem_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam int unsigned MaxAddrWidth = 64;

  // WRAP deliberately advances like INCR.
  function automatic logic [MaxAddrWidth-1:0] axi_mem_next_addr(
    input logic [MaxAddrWidth-1:0] addr,
    input logic [2:0]              size,
    input logic [1:0]              burst
  );
    logic [MaxAddrWidth-1:0] step;
    step = MaxAddrWidth'(1) << size;
    return (burst == BurstFixed) ? addr : addr + step;
  endfunction

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } axi_mem_ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } axi_mem_w_chan_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } axi_mem_b_chan_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } axi_mem_r_chan_t;

  typedef struct packed {
    axi_mem_ax_chan_t aw;
    logic             aw_valid;
    axi_mem_w_chan_t  w;
    logic             w_valid;
    logic             b_ready;
    axi_mem_ax_chan_t ar;
    logic             ar_valid;
    logic             r_ready;
  } axi_mem_req_t;

  typedef struct packed {
    logic            aw_ready;
    logic            ar_ready;
    logic            w_ready;
    logic            b_valid;
    axi_mem_b_chan_t b;
    logic            r_valid;
    axi_mem_r_chan_t r;
  } axi_mem_rsp_t;

endpackage

// File: rtl/axi_mem_bank.sv
// Word-wide flop memory with per-byte write enables; write on the clock edge, read combinationally.
// Contents are never reset so preloaded or written data survives a responder reset.
module axi_mem_bank #(
  parameter int unsigned Words     = 512,
  parameter int unsigned DataWidth = 64
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [DataWidth/8-1:0]     be_i,
  input  logic [$clog2(Words)-1:0]   addr_i,
  input  logic [DataWidth-1:0]       wdata_i,
  output logic [DataWidth-1:0]       rdata_o
);

  localparam int unsigned StrbW = DataWidth / 8;

  logic [DataWidth-1:0] mem_q [Words];
  logic [DataWidth-1:0] word_d;

  always_comb begin
    word_d = mem_q[addr_i];
    for (int b = 0; b < StrbW; b++) begin
      if (be_i[b]) word_d[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= word_d;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by flop memory, one transaction at a time; R beat 0 and B one cycle after AR / last W.
// B/R hold until accepted; W/R may stall forever. AXI_MEM_RESP_ERR_EN enables SLVERR on out-of-range beats.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          IdWidth   = 8,
  parameter int unsigned          UserWidth = 1,
  parameter int unsigned          MemBytes  = 4096,
  parameter logic [AddrWidth-1:0] BaseAddr  = 64'h8000_0000,
  parameter type                  axi_req_t  = axi_mem_responder_pkg::axi_mem_req_t,
  parameter type                  axi_resp_t = axi_mem_responder_pkg::axi_mem_rsp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_rsp_o,
  output logic      busy_o
);

  localparam int unsigned StrbW   = DataWidth / 8;
  localparam int unsigned SizeMax = $clog2(StrbW);
  localparam int unsigned MemAw   = $clog2(MemBytes);
  localparam int unsigned Words   = MemBytes / StrbW;
  localparam int unsigned WordAw  = MemAw - SizeMax;
  localparam logic [2:0]  SizeCap = 3'(SizeMax);

  axi_mem_state_e       state_q, state_d;
  logic                 live_q, live_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic                 err_q, err_d;

  logic                 aw_rdy, aw_hs, ar_hs;
  logic [IdWidth-1:0]   req_id;
  logic [AddrWidth-1:0] req_addr, req_mask;
  logic [7:0]           req_len;
  logic [2:0]           req_size;
  logic [1:0]           req_burst;
  logic [AddrWidth-1:0] offset, next_addr;
  logic [WordAw-1:0]    word_idx;
  logic                 in_range, mem_we;
  logic [DataWidth-1:0] rd_word;

  assign aw_rdy = live_q && (state_q == StIdle);
  assign aw_hs  = aw_rdy && axi_req_i.aw_valid;
  assign ar_hs  = aw_rdy && !axi_req_i.aw_valid && axi_req_i.ar_valid;
  assign busy_o = (state_q != StIdle);

  // Writes win arbitration, so the latched request comes from AW whenever it is valid.
  always_comb begin
    req_id    = axi_req_i.aw_valid ? axi_req_i.aw.id    : axi_req_i.ar.id;
    req_addr  = axi_req_i.aw_valid ? axi_req_i.aw.addr  : axi_req_i.ar.addr;
    req_len   = axi_req_i.aw_valid ? axi_req_i.aw.len   : axi_req_i.ar.len;
    req_size  = axi_req_i.aw_valid ? axi_req_i.aw.size  : axi_req_i.ar.size;
    req_burst = axi_req_i.aw_valid ? axi_req_i.aw.burst : axi_req_i.ar.burst;
    if (req_size > SizeCap) req_size = SizeCap;
    req_mask  = ~((AddrWidth'(1) << req_size) - AddrWidth'(1));
  end

  assign offset    = addr_q - BaseAddr;
  assign word_idx  = offset[MemAw-1:SizeMax];
  assign next_addr = AddrWidth'(axi_mem_next_addr(MaxAddrWidth'(addr_q), size_q, burst_q));

`ifdef AXI_MEM_RESP_ERR_EN
  assign in_range = (offset[AddrWidth-1:MemAw] == '0);
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    live_d  = 1'b1;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs || ar_hs) begin
          id_d    = req_id;
          addr_d  = req_addr & req_mask;
          len_d   = req_len;
          size_d  = req_size;
          burst_d = req_burst;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = aw_hs ? StWdata : StRdata;
        end
      end
      StWdata: begin
        if (axi_req_i.w_valid) begin
          addr_d = next_addr;
          if (!in_range) err_d = 1'b1;
          if (axi_req_i.w.last) state_d = StWresp;
        end
      end
      StWresp: begin
        if (axi_req_i.b_ready) state_d = StIdle;
      end
      StRdata: begin
        if (axi_req_i.r_ready) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      live_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  assign mem_we = rst_ni && (state_q == StWdata) && axi_req_i.w_valid && in_range;

  axi_mem_bank #(
    .Words     (Words),
    .DataWidth (DataWidth)
  ) u_bank (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .be_i    (axi_req_i.w.strb),
    .addr_i  (word_idx),
    .wdata_i (axi_req_i.w.data),
    .rdata_o (rd_word)
  );

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_rdy;
    axi_rsp_o.ar_ready = aw_rdy && !axi_req_i.aw_valid;
    axi_rsp_o.w_ready  = (state_q == StWdata);
    axi_rsp_o.b_valid  = (state_q == StWresp);
    axi_rsp_o.r_valid  = (state_q == StRdata);
    if (state_q == StWresp) begin
      axi_rsp_o.b.id   = id_q;
      axi_rsp_o.b.resp = err_q ? RespSlvErr : RespOkay;
    end
    if (state_q == StRdata) begin
      axi_rsp_o.r.id   = id_q;
      axi_rsp_o.r.last = (cnt_q == len_q);
      axi_rsp_o.r.resp = in_range ? RespOkay : RespSlvErr;
      axi_rsp_o.r.data = in_range ? rd_word : '0;
    end
  end

  logic unused_req;
  assign unused_req = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                        axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.user,
                        axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot,
                        axi_req_i.ar.qos, axi_req_i.ar.region, axi_req_i.ar.user,
                        axi_req_i.w.user, offset[AddrWidth-1:MemAw], offset[SizeMax-1:0],
                        UserWidth[0]};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: stimulus pushes expected B/R responses, a monitor pops and compares.
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_ni;
  axi_mem_req_t req;
  axi_mem_rsp_t rsp;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];

  axi_mem_responder dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .axi_req_i (req),
    .axi_rsp_o (rsp),
    .busy_o    (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic exp_b(input logic [7:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    b_q.push_back(e);
  endtask

  task automatic exp_r(input logic [7:0] id, input logic [63:0] data, input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every B/R handshake and checks R stability while stalled.
  initial begin : monitor
    b_exp_t be;
    r_exp_t re;
    axi_mem_r_chan_t r_prev;
    logic hold;
    hold = 1'b0;
    r_prev = '0;
    forever begin
      @(negedge clk);
      if (rsp.b_valid && req.b_ready) begin
        if (b_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected: got B id %0h, required no B", rsp.b.id);
        end else begin
          be = b_q.pop_front();
          check("b_id", 128'(rsp.b.id), 128'(be.id));
          check("b_resp", 128'(rsp.b.resp), 128'(be.resp));
        end
      end
      if (rsp.r_valid) begin
        if (hold) check("r_stable", 128'(rsp.r), 128'(r_prev));
        if (req.r_ready) begin
          hold = 1'b0;
          if (r_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL r_unexpected: got R data %0h, required no R", rsp.r.data);
          end else begin
            re = r_q.pop_front();
            check("r_id", 128'(rsp.r.id), 128'(re.id));
            check("r_data", 128'(rsp.r.data), 128'(re.data));
            check("r_resp", 128'(rsp.r.resp), 128'(re.resp));
            check("r_last", 128'(rsp.r.last), 128'(re.last));
          end
        end else begin
          hold = 1'b1;
          r_prev = rsp.r;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic send_aw(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n;
    req.aw.id = id; req.aw.addr = addr; req.aw.len = len; req.aw.size = 3'd3; req.aw.burst = burst;
    req.aw_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp.aw_ready && n < 50);
    check("aw_hs_timeout", 128'(rsp.aw_ready), 128'(1));
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    check("w_ready_after_aw", 128'(rsp.w_ready), 128'(1));
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n;
    req.w.data = data; req.w.strb = strb; req.w.last = last; req.w_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp.w_ready && n < 50);
    check("w_hs_timeout", 128'(rsp.w_ready), 128'(1));
    @(posedge clk); #1;
    req.w_valid = 1'b0; req.w.last = 1'b0;
    if (last) check("b_valid_after_wlast", 128'(rsp.b_valid), 128'(1));
  endtask

  task automatic do_read(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic stall);
    int n;
    int beats;
    req.ar.id = id; req.ar.addr = addr; req.ar.len = len; req.ar.size = 3'd3; req.ar.burst = burst;
    req.ar_valid = 1'b1;
    req.r_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp.ar_ready && n < 50);
    check("ar_hs_timeout", 128'(rsp.ar_ready), 128'(1));
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    check("r_valid_after_ar", 128'(rsp.r_valid), 128'(1));
    beats = 0; n = 0;
    while (beats <= int'(len) && n < 100) begin
      @(negedge clk);
      if (rsp.r_valid && req.r_ready) beats++;
      @(posedge clk); #1;
      if (stall) req.r_ready = ~req.r_ready;
      n++;
    end
    req.r_ready = 1'b1;
    check("r_beats_timeout", 128'(n < 100), 128'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || b_q.size() != 0 || r_q.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("drain_timeout", 128'(n < 100), 128'(1));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    n_fail++;
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_ni = 1'b0;
    req = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;

    // Reset state and ready release timing
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp", 128'(rsp), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check("aw_ready_before_edge", 128'(rsp.aw_ready), 128'(0));
    @(posedge clk); #1;
    check("aw_ready_after_rst", 128'(rsp.aw_ready), 128'(1));
    check("ar_ready_after_rst", 128'(rsp.ar_ready), 128'(1));

    // Single write then read-back
    exp_b(8'h03, RespOkay);
    send_aw(8'h03, 64'h8000_0000, 8'd0, BurstIncr);
    check("busy_in_write", 128'(busy), 128'(1));
    send_w(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
    drain();
    exp_r(8'h05, 64'hDEAD_BEEF_0123_4567, RespOkay, 1'b1);
    do_read(8'h05, 64'h8000_0000, 8'd0, BurstIncr, 1'b0);
    drain();

    // INCR burst, read back with r_ready toggling
    exp_b(8'h01, RespOkay);
    send_aw(8'h01, 64'h8000_0100, 8'd3, BurstIncr);
    for (int i = 0; i < 4; i++) send_w(64'(i + 1), 8'hFF, 1'(i == 3));
    drain();
    for (int i = 0; i < 4; i++) exp_r(8'h02, 64'(i + 1), RespOkay, 1'(i == 3));
    do_read(8'h02, 64'h8000_0100, 8'd3, BurstIncr, 1'b1);
    drain();

    // Partial strobe then FIXED burst
    exp_b(8'h07, RespOkay);
    send_aw(8'h07, 64'h8000_0008, 8'd0, BurstIncr);
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    exp_b(8'h08, RespOkay);
    send_aw(8'h08, 64'h8000_0008, 8'd0, BurstIncr);
    send_w(64'h0, 8'h0F, 1'b1);
    drain();
    exp_r(8'h06, 64'hFFFF_FFFF_0000_0000, RespOkay, 1'b1);
    do_read(8'h06, 64'h8000_0008, 8'd0, BurstIncr, 1'b0);
    for (int i = 0; i < 3; i++) exp_r(8'h0A, 64'hFFFF_FFFF_0000_0000, RespOkay, 1'(i == 2));
    do_read(8'h0A, 64'h8000_0008, 8'd2, BurstFixed, 1'b0);
    drain();

    // Simultaneous AW and AR: write first, read after B sees the new data
    exp_b(8'h11, RespOkay);
    exp_r(8'h12, 64'hA5A5_5A5A_1234_8765, RespOkay, 1'b1);
    req.aw.id = 8'h11; req.aw.addr = 64'h8000_0010; req.aw.len = 8'd0; req.aw.size = 3'd3; req.aw.burst = BurstIncr;
    req.ar.id = 8'h12; req.ar.addr = 64'h8000_0010; req.ar.len = 8'd0; req.ar.size = 3'd3; req.ar.burst = BurstIncr;
    req.aw_valid = 1'b1; req.ar_valid = 1'b1;
    @(negedge clk);
    check("arb_aw_ready", 128'(rsp.aw_ready), 128'(1));
    check("arb_ar_ready_blocked", 128'(rsp.ar_ready), 128'(0));
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w.data = 64'hA5A5_5A5A_1234_8765; req.w.strb = 8'hFF; req.w.last = 1'b1; req.w_valid = 1'b1;
    @(negedge clk);
    check("arb_w_ready", 128'(rsp.w_ready), 128'(1));
    check("arb_ar_ready_wdata", 128'(rsp.ar_ready), 128'(0));
    @(posedge clk); #1;
    req.w_valid = 1'b0; req.w.last = 1'b0;
    check("arb_b_valid", 128'(rsp.b_valid), 128'(1));
    check("arb_ar_ready_wresp", 128'(rsp.ar_ready), 128'(0));
    @(posedge clk); #1;
    check("arb_ar_ready_after_b", 128'(rsp.ar_ready), 128'(1));
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    check("arb_r_valid", 128'(rsp.r_valid), 128'(1));
    drain();

    // Out-of-range read
`ifdef AXI_MEM_RESP_ERR_EN
    exp_r(8'h09, 64'h0, RespSlvErr, 1'b1);
    do_read(8'h09, 64'h8000_1000, 8'd0, BurstIncr, 1'b0);
    exp_b(8'h0B, RespSlvErr);
    send_aw(8'h0B, 64'h8000_1000, 8'd0, BurstIncr);
    send_w(64'h1111_2222_3333_4444, 8'hFF, 1'b1);
    drain();
    exp_r(8'h0C, 64'hDEAD_BEEF_0123_4567, RespOkay, 1'b1);
    do_read(8'h0C, 64'h8000_0000, 8'd0, BurstIncr, 1'b0);
`else
    exp_r(8'h09, 64'hDEAD_BEEF_0123_4567, RespOkay, 1'b1);
    do_read(8'h09, 64'h8000_1000, 8'd0, BurstIncr, 1'b0);
`endif
    drain();

    // Reset in the middle of a write burst
    send_aw(8'h04, 64'h8000_0200, 8'd3, BurstIncr);
    send_w(64'h11, 8'hFF, 1'b0);
    send_w(64'h22, 8'hFF, 1'b0);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check("midrst_rsp", 128'(rsp), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("midrst_aw_ready", 128'(rsp.aw_ready), 128'(1));
    exp_r(8'h13, 64'h11, RespOkay, 1'b0);
    exp_r(8'h13, 64'h22, RespOkay, 1'b1);
    do_read(8'h13, 64'h8000_0200, 8'd1, BurstIncr, 1'b0);
    drain();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
